// File: rtl/unidade_controle_pkg.sv
// Shared encodings for the instruction control unit: opcodes, immediate formats,
// ULA operations, write-back / PC selects and FSM state encoding.
package unidade_controle_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_J = 3'd1;
  localparam logic [2:0] IMM_U = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_S = 3'd4;

  localparam logic [1:0] ULA_NAO     = 2'd0;
  localparam logic [1:0] ULA_SOMA    = 2'd1;
  localparam logic [1:0] ULA_SUBTRAI = 2'd2;

  localparam logic [1:0] WB_ULA = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] PC_MAIS4    = 2'd0;
  localparam logic [1:0] PC_MAIS_IMM = 2'd1;
  localparam logic [1:0] PC_ULA      = 2'd2;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    ERRO       = 3'd5
  } estado_t;

  function automatic logic opcode_valido(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_STORE, OP_REG, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_valido = 1'b1;
      default:                           opcode_valido = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/unidade_controle_avaliador_desvio.sv
// Branch condition evaluator: maps funct3 and the ULA comparison flags to a
// taken decision, flagging funct3 codes that are not branch conditions.
module avaliador_desvio (
  input  logic [2:0] funct3_i,
  input  logic       flag_igual_i,
  input  logic       flag_menor_i,
  input  logic       flag_maior_igual_u_i,
  output logic       tomado_o,
  output logic       invalido_o
);

  always_comb begin
    tomado_o   = 1'b0;
    invalido_o = 1'b0;
    case (funct3_i)
      3'b000:  tomado_o   = flag_igual_i;
      3'b001:  tomado_o   = !flag_igual_i;
      3'b100:  tomado_o   = flag_menor_i;
      3'b101:  tomado_o   = !flag_menor_i;
      3'b110:  tomado_o   = !flag_maior_igual_u_i;
      3'b111:  tomado_o   = flag_maior_igual_u_i;
      default: invalido_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle instruction control FSM: fetch, decode, execute, memory and
// write-back sequencing with a memory wait watchdog and a sticky error state.
//   state      | meaning
//   BUSCA      | instruction fetch, wait for mem_ready, load IR
//   DECODIFICA | latch opcode/funct3, reject illegal opcodes
//   EXECUTA    | drive ULA controls; branches resolve here
//   MEMORIA    | data access for load/store, wait for mem_ready
//   ESCRITA    | register write-back and PC update
//   ERRO       | absorbing until reset
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] upcode,
  input  logic [2:0] funct3,
  input  logic       flag_igual,
  input  logic       flag_menor,
  input  logic       flag_maior_igual_u,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       WeR,
  output logic [2:0] select_imm,
  output logic [1:0] soma_ou_subtrai,
  output logic       usa_imm,
  output logic [1:0] wb_sel,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       erro
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  estado_t       state_q, state_d;
  logic [6:0]    opcode_q, opcode_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [CW-1:0] espera_q, espera_d;
  logic          run_q;
  logic          desvio_tomado, desvio_invalido;

  avaliador_desvio u_avaliador (
    .funct3_i            (funct3_q),
    .flag_igual_i        (flag_igual),
    .flag_menor_i        (flag_menor),
    .flag_maior_igual_u_i(flag_maior_igual_u),
    .tomado_o            (desvio_tomado),
    .invalido_o          (desvio_invalido)
  );

  // run_q keeps BUSCA quiet while in reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BUSCA;
      opcode_q <= '0;
      funct3_q <= '0;
      espera_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      espera_q <= espera_d;
      run_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    opcode_d        = opcode_q;
    funct3_d        = funct3_q;
    espera_d        = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    ir_we           = 1'b0;
    WeR             = 1'b0;
    select_imm      = IMM_I;
    soma_ou_subtrai = ULA_NAO;
    usa_imm         = 1'b0;
    wb_sel          = WB_ULA;
    pc_we           = 1'b0;
    pc_sel          = PC_MAIS4;
    erro            = 1'b0;

    // ULA controls stay stable through MEMORIA/ESCRITA so address and JALR target hold.
    if (state_q == EXECUTA || state_q == MEMORIA || state_q == ESCRITA) begin
      case (opcode_q)
        OP_LOAD, OP_IMM, OP_JALR: begin
          select_imm = IMM_I; soma_ou_subtrai = ULA_SOMA; usa_imm = 1'b1;
        end
        OP_STORE: begin
          select_imm = IMM_S; soma_ou_subtrai = ULA_SOMA; usa_imm = 1'b1;
        end
        OP_REG:    soma_ou_subtrai = ULA_SOMA;
        OP_BRANCH: begin
          select_imm = IMM_B; soma_ou_subtrai = ULA_SUBTRAI;
        end
        OP_JAL:    select_imm = IMM_J;
        OP_LUI:    select_imm = IMM_U;
        OP_AUIPC: begin
          select_imm = IMM_U; soma_ou_subtrai = ULA_SOMA; usa_imm = 1'b1;
        end
        default: ;
      endcase
    end

    case (state_q)
      BUSCA: begin
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = DECODIFICA;
          end else if (espera_q == CW'(MEM_TIMEOUT - 1)) begin
            state_d = ERRO;
          end else begin
            espera_d = espera_q + CW'(1);
          end
        end
      end
      DECODIFICA: begin
        opcode_d = upcode;
        funct3_d = funct3;
        state_d  = opcode_valido(upcode) ? EXECUTA : ERRO;
      end
      EXECUTA: begin
        case (opcode_q)
          OP_BRANCH: begin
            if (desvio_invalido) begin
              state_d = ERRO;
            end else begin
              pc_we   = 1'b1;
              pc_sel  = desvio_tomado ? PC_MAIS_IMM : PC_MAIS4;
              state_d = BUSCA;
            end
          end
          OP_LOAD, OP_STORE: state_d = MEMORIA;
          default:           state_d = ESCRITA;
        endcase
      end
      MEMORIA: begin
        mem_req = 1'b1;
        mem_we  = (opcode_q == OP_STORE);
        if (mem_ready) begin
          if (opcode_q == OP_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_MAIS4;
            state_d = BUSCA;
          end else begin
            state_d = ESCRITA;
          end
        end else if (espera_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d = ERRO;
        end else begin
          espera_d = espera_q + CW'(1);
        end
      end
      ESCRITA: begin
        WeR     = 1'b1;
        pc_we   = 1'b1;
        state_d = BUSCA;
        case (opcode_q)
          OP_LOAD:         wb_sel = WB_MEM;
          OP_JAL, OP_JALR: wb_sel = WB_PC4;
          OP_LUI:          wb_sel = WB_IMM;
          default:         wb_sel = WB_ULA;
        endcase
        case (opcode_q)
          OP_JAL:  pc_sel = PC_MAIS_IMM;
          OP_JALR: pc_sel = PC_ULA;
          default: pc_sel = PC_MAIS4;
        endcase
      end
      ERRO: begin
        erro            = 1'b1;
        select_imm      = IMM_I;
        soma_ou_subtrai = ULA_NAO;
        usa_imm         = 1'b0;
      end
      default: state_d = ERRO;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle (MEM_TIMEOUT = 4).
module tb_unidade_controle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] upcode;
  logic [2:0] funct3;
  logic       flag_igual, flag_menor, flag_maior_igual_u;
  logic       mem_ready;
  logic       mem_req, mem_we, ir_we, WeR, usa_imm, pc_we, erro;
  logic [2:0] select_imm;
  logic [1:0] soma_ou_subtrai, wb_sel, pc_sel;

  int n_chk  = 0;
  int n_fail = 0;

  unidade_controle #(.MEM_TIMEOUT(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .upcode            (upcode),
    .funct3            (funct3),
    .flag_igual        (flag_igual),
    .flag_menor        (flag_menor),
    .flag_maior_igual_u(flag_maior_igual_u),
    .mem_ready         (mem_ready),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .ir_we             (ir_we),
    .WeR               (WeR),
    .select_imm        (select_imm),
    .soma_ou_subtrai   (soma_ou_subtrai),
    .usa_imm           (usa_imm),
    .wb_sel            (wb_sel),
    .pc_we             (pc_we),
    .pc_sel            (pc_sel),
    .erro              (erro)
  );

  always #5 clk = ~clk;

  // Advance to the next cycle; outputs are sampled 2 time units after the edge.
  task automatic prox();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench in cycle 1 (first BUSCA cycle with mem_req).
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; upcode = '0; funct3 = '0;
    flag_igual = 1'b0; flag_menor = 1'b0; flag_maior_igual_u = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prox();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; mem_ready = 1'b1; upcode = 7'b0110011; funct3 = '0;
    flag_igual = 1'b0; flag_menor = 1'b0; flag_maior_igual_u = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if ({mem_req, mem_we, ir_we, WeR, pc_we, erro} !== 6'b0) begin
      n_fail++; $display("FAIL reset_enables: got %b expected 000000", {mem_req, mem_we, ir_we, WeR, pc_we, erro});
    end
    prox();
    n_chk++; if (mem_req !== 1'b0 || ir_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_held_edge: mem_req=%b ir_we=%b expected 0 0", mem_req, ir_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_before_edge: mem_req=%b expected 0", mem_req);
    end
    prox();
    n_chk++; if (mem_req !== 1'b1 || ir_we !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_req: mem_req=%b ir_we=%b expected 1 1", mem_req, ir_we);
    end
  endtask

  // Instructions that pass through ESCRITA without MEMORIA (4-cycle latency).
  task automatic test_escrita(input logic [6:0] op, input logic chk_exe, input logic [2:0] e_imm,
                              input logic [1:0] e_ula, input logic e_usa, input logic [1:0] e_wb,
                              input logic [1:0] e_pc, input string nome);
    do_reset();
    mem_ready = 1'b1; upcode = op; funct3 = 3'b000;
    #1;
    n_chk++; if (ir_we !== 1'b1) begin
      n_fail++; $display("FAIL %s_c1_ir_we: got %b expected 1", nome, ir_we);
    end
    prox();
    n_chk++; if (ir_we !== 1'b0 || WeR !== 1'b0 || pc_we !== 1'b0) begin
      n_fail++; $display("FAIL %s_c2_quiet: ir_we=%b WeR=%b pc_we=%b expected 0 0 0", nome, ir_we, WeR, pc_we);
    end
    prox();
    n_chk++; if (WeR !== 1'b0 || pc_we !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL %s_c3_quiet: WeR=%b pc_we=%b mem_req=%b expected 0 0 0", nome, WeR, pc_we, mem_req);
    end
    if (chk_exe) begin
      n_chk++; if (select_imm !== e_imm || soma_ou_subtrai !== e_ula || usa_imm !== e_usa) begin
        n_fail++; $display("FAIL %s_c3_ula: imm=%0d ula=%0d usa=%b expected %0d %0d %b",
                           nome, select_imm, soma_ou_subtrai, usa_imm, e_imm, e_ula, e_usa);
      end
    end
    prox();
    n_chk++; if (WeR !== 1'b1 || pc_we !== 1'b1 || wb_sel !== e_wb || pc_sel !== e_pc || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL %s_c4_wb: WeR=%b pc_we=%b wb_sel=%0d pc_sel=%0d mem_we=%b expected 1 1 %0d %0d 0",
                         nome, WeR, pc_we, wb_sel, pc_sel, mem_we, e_wb, e_pc);
    end
    prox();
    n_chk++; if (mem_req !== 1'b1 || WeR !== 1'b0) begin
      n_fail++; $display("FAIL %s_c5_refetch: mem_req=%b WeR=%b expected 1 0", nome, mem_req, WeR);
    end
  endtask

  task automatic run_branch(input logic [2:0] f3, input logic ig, input logic me, input logic mgu,
                            input logic e_tomado, input string nome);
    do_reset();
    mem_ready = 1'b1; upcode = 7'b1100011; funct3 = f3;
    prox();
    prox();
    flag_igual = ig; flag_menor = me; flag_maior_igual_u = mgu;
    #1;
    n_chk++; if (pc_we !== 1'b1 || pc_sel !== {1'b0, e_tomado} || WeR !== 1'b0) begin
      n_fail++; $display("FAIL %s_c3_pc: pc_we=%b pc_sel=%0d WeR=%b expected 1 %0d 0", nome, pc_we, pc_sel, WeR, e_tomado);
    end
    n_chk++; if (soma_ou_subtrai !== 2'd2 || select_imm !== 3'd3 || usa_imm !== 1'b0) begin
      n_fail++; $display("FAIL %s_c3_ula: ula=%0d imm=%0d usa=%b expected 2 3 0", nome, soma_ou_subtrai, select_imm, usa_imm);
    end
    prox();
    n_chk++; if (mem_req !== 1'b1 || WeR !== 1'b0 || erro !== 1'b0) begin
      n_fail++; $display("FAIL %s_c4_refetch: mem_req=%b WeR=%b erro=%b expected 1 0 0", nome, mem_req, WeR, erro);
    end
  endtask

  task automatic test_branch();
    run_branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, "beq_taken");
    run_branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, "bne_not");
    run_branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, "blt_taken");
    run_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, "bge_not");
    run_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b1, "bltu_taken");
    run_branch(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, "bgeu_not");
    do_reset();
    mem_ready = 1'b1; upcode = 7'b1100011; funct3 = 3'b010;
    prox();
    prox();
    #1;
    n_chk++; if (pc_we !== 1'b0) begin
      n_fail++; $display("FAIL branch_bad_f3_pc_we: got %b expected 0", pc_we);
    end
    prox();
    n_chk++; if (erro !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL branch_bad_f3_erro: erro=%b mem_req=%b expected 1 0", erro, mem_req);
    end
  endtask

  task automatic test_load();
    int req_cnt = 0;
    do_reset();
    mem_ready = 1'b1; upcode = 7'b0000011; funct3 = 3'b010;
    prox();
    prox();
    n_chk++; if (select_imm !== 3'd0 || soma_ou_subtrai !== 2'd1 || usa_imm !== 1'b1) begin
      n_fail++; $display("FAIL lw_c3_ula: imm=%0d ula=%0d usa=%b expected 0 1 1", select_imm, soma_ou_subtrai, usa_imm);
    end
    mem_ready = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      prox();
      mem_ready = (c == 7);
      #1;
      if (mem_req === 1'b1) req_cnt++;
      if (c < 8) begin
        n_chk++; if (WeR !== 1'b0 || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL lw_c%0d_quiet: WeR=%b mem_we=%b expected 0 0", c, WeR, mem_we);
        end
      end
    end
    n_chk++; if (WeR !== 1'b1 || wb_sel !== 2'd1 || pc_we !== 1'b1 || pc_sel !== 2'd0) begin
      n_fail++; $display("FAIL lw_c8_wb: WeR=%b wb_sel=%0d pc_we=%b pc_sel=%0d expected 1 1 1 0", WeR, wb_sel, pc_we, pc_sel);
    end
    n_chk++; if (req_cnt !== 4) begin
      n_fail++; $display("FAIL lw_mem_req_cycles: got %0d expected 4", req_cnt);
    end
  endtask

  task automatic test_store();
    int wer_cnt = 0;
    do_reset();
    mem_ready = 1'b1; upcode = 7'b0100011; funct3 = 3'b010;
    #1;
    if (WeR === 1'b1) wer_cnt++;
    n_chk++; if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL sw_c1_mem_we: got %b expected 0", mem_we);
    end
    prox();
    if (WeR === 1'b1) wer_cnt++;
    prox();
    if (WeR === 1'b1) wer_cnt++;
    n_chk++; if (mem_we !== 1'b0 || select_imm !== 3'd4 || usa_imm !== 1'b1 || soma_ou_subtrai !== 2'd1) begin
      n_fail++; $display("FAIL sw_c3: mem_we=%b imm=%0d usa=%b ula=%0d expected 0 4 1 1", mem_we, select_imm, usa_imm, soma_ou_subtrai);
    end
    prox();
    if (WeR === 1'b1) wer_cnt++;
    n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 2'd0) begin
      n_fail++; $display("FAIL sw_c4_mem: mem_req=%b mem_we=%b pc_we=%b pc_sel=%0d expected 1 1 1 0", mem_req, mem_we, pc_we, pc_sel);
    end
    prox();
    if (WeR === 1'b1) wer_cnt++;
    n_chk++; if (mem_we !== 1'b0 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL sw_c5_refetch: mem_we=%b mem_req=%b expected 0 1", mem_we, mem_req);
    end
    n_chk++; if (wer_cnt !== 0) begin
      n_fail++; $display("FAIL sw_wer_cycles: got %0d expected 0", wer_cnt);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    mem_ready = 1'b1; upcode = 7'b1111111; funct3 = 3'b000;
    prox();
    n_chk++; if (erro !== 1'b0) begin
      n_fail++; $display("FAIL illegal_c2_erro: got %b expected 0", erro);
    end
    prox();
    n_chk++; if (erro !== 1'b1) begin
      n_fail++; $display("FAIL illegal_c3_erro: got %b expected 1", erro);
    end
    upcode = 7'b0110011;
    for (int c = 0; c < 8; c++) prox();
    n_chk++; if (erro !== 1'b1 || {mem_req, mem_we, ir_we, WeR, pc_we} !== 5'b0) begin
      n_fail++; $display("FAIL illegal_sticky: erro=%b enables=%b expected 1 00000", erro, {mem_req, mem_we, ir_we, WeR, pc_we});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_ready = 1'b0;
    prox();
    prox();
    prox();
    n_chk++; if (erro !== 1'b0 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL timeout_c4: erro=%b mem_req=%b expected 0 1", erro, mem_req);
    end
    prox();
    n_chk++; if (erro !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL timeout_c5: erro=%b mem_req=%b expected 1 0", erro, mem_req);
    end
  endtask

  task automatic test_reset_memoria();
    do_reset();
    mem_ready = 1'b1; upcode = 7'b0000011; funct3 = 3'b010;
    prox();
    prox();
    mem_ready = 1'b0;
    prox();
    n_chk++; if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rstmem_in_memoria: mem_req=%b expected 1", mem_req);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (mem_req !== 1'b0 || WeR !== 1'b0 || pc_we !== 1'b0) begin
      n_fail++; $display("FAIL rstmem_async_drop: mem_req=%b WeR=%b pc_we=%b expected 0 0 0", mem_req, WeR, pc_we);
    end
    mem_ready = 1'b1;
    prox();
    n_chk++; if (WeR !== 1'b0 || pc_we !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmem_held: WeR=%b pc_we=%b mem_req=%b expected 0 0 0", WeR, pc_we, mem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prox();
    n_chk++; if (mem_req !== 1'b1 || ir_we !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rstmem_restart: mem_req=%b ir_we=%b mem_we=%b expected 1 1 0", mem_req, ir_we, mem_we);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_ready = 1'b1; upcode = 7'b0110111; funct3 = 3'b000;
    prox();
    prox();
    prox();
    n_chk++; if (WeR !== 1'b1 || wb_sel !== 2'd3) begin
      n_fail++; $display("FAIL b2b_lui_wb: WeR=%b wb_sel=%0d expected 1 3", WeR, wb_sel);
    end
    upcode = 7'b1100011; funct3 = 3'b000; flag_igual = 1'b1;
    prox();
    n_chk++; if (ir_we !== 1'b1) begin
      n_fail++; $display("FAIL b2b_fetch2: ir_we=%b expected 1", ir_we);
    end
    prox();
    prox();
    n_chk++; if (pc_we !== 1'b1 || pc_sel !== 2'd1 || WeR !== 1'b0) begin
      n_fail++; $display("FAIL b2b_beq: pc_we=%b pc_sel=%0d WeR=%b expected 1 1 0", pc_we, pc_sel, WeR);
    end
  endtask

  initial begin
    test_reset();
    test_escrita(7'b0110011, 1'b1, 3'd0, 2'd1, 1'b0, 2'd0, 2'd0, "add");
    test_escrita(7'b0010011, 1'b1, 3'd0, 2'd1, 1'b1, 2'd0, 2'd0, "addi");
    test_escrita(7'b1100111, 1'b1, 3'd0, 2'd1, 1'b1, 2'd2, 2'd2, "jalr");
    test_escrita(7'b1101111, 1'b0, 3'd0, 2'd0, 1'b0, 2'd2, 2'd1, "jal");
    test_escrita(7'b0110111, 1'b0, 3'd0, 2'd0, 1'b0, 2'd3, 2'd0, "lui");
    test_escrita(7'b0010111, 1'b0, 3'd0, 2'd0, 1'b0, 2'd0, 2'd0, "auipc");
    test_branch();
    test_load();
    test_store();
    test_illegal();
    test_timeout();
    test_reset_memoria();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
